// File: rtl/vga_spi_pkg.sv
// vga_spi_pkg: shared SPI ROM read constants and fetch FSM states.
package vga_spi_pkg;
  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int SPI_ADDR_W = 24;
  typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} fsm_e;
endpackage

// File: rtl/spi_read_engine.sv
// spi_read_engine: mode-0 SPI READ sequencer streaming DATA_BITS serial bits with their index.
module spi_read_engine
  import vga_spi_pkg::*;
#(
  parameter int DATA_BITS = 176,
  parameter int IW = $clog2(DATA_BITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [SPI_ADDR_W-1:0] addr_i,
  input  logic                  miso_i,
  output logic                  cs_n_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  output logic                  busy_o,
  output logic                  bit_valid_o,
  output logic [IW-1:0]         bit_idx_o,
  output logic                  bit_o
);
  localparam int SW = 8 + SPI_ADDR_W;
  localparam int TOTAL = SW + DATA_BITS;
  localparam int CW = $clog2(TOTAL);

  fsm_e          state_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] sh_q;
  logic          cs_n_q, sclk_q, busy_q;

  // A start always wins, so a new line restarts the sequence even mid-transfer.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      state_q <= CMD;
      cnt_q   <= '0;
      sh_q    <= {SPI_CMD_READ, addr_i};
      cs_n_q  <= 1'b0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else if (state_q != IDLE) begin
      sclk_q <= ~sclk_q;
      if (sclk_q) begin
        if (cnt_q == CW'(TOTAL - 1)) begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          cnt_q   <= cnt_q + 1'b1;
          sh_q    <= sh_q << 1;
          state_q <= cnt_q == CW'(7) ? ADDR : cnt_q == CW'(SW - 1) ? DATA : state_q;
        end
      end
    end

  // The shifter drains to zero after the header, which keeps mosi low during DATA.
  assign cs_n_o      = cs_n_q;
  assign sclk_o      = sclk_q;
  assign mosi_o      = sh_q[SW-1];
  assign busy_o      = busy_q;
  assign bit_valid_o = state_q == DATA && sclk_q;
  assign bit_idx_o   = IW'(cnt_q - CW'(SW));
  assign bit_o       = miso_i;
endmodule

// File: rtl/spi_line_fetch.sv
// spi_line_fetch: double-buffered 1bpp line fetch from SPI ROM feeding a registered pixel stream.
module spi_line_fetch
  import vga_spi_pkg::*;
#(
  parameter int                    LINE_BYTES = 22,
  parameter logic [SPI_ADDR_W-1:0] BASE_ADDR  = 24'h000000,
  parameter int                    H_TOTAL    = 476
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hpos,
  input  logic       hmax,
  input  logic       vmax,
  input  logic       visible,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       pixel,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       busy,
  output logic       underrun
);
  localparam int NB = LINE_BYTES * 8;
  localparam int IW = $clog2(NB);

  if (2 * (32 + NB) + 2 > H_TOTAL) begin : g_bad_timing
    $error("H_TOTAL too short to fetch LINE_BYTES per line");
  end

  logic [1:0][NB-1:0]    bank_q;
  logic [NB-1:0]         front;
  logic                  front_q, pixel_q, hsync_q, vsync_q, underrun_q;
  logic [SPI_ADDR_W-1:0] line_addr_q, target;
  logic [8:0]            idx;
  logic                  bit_valid, bit_val;
  logic [IW-1:0]         bit_idx;

  assign target = vmax ? BASE_ADDR : line_addr_q;
  assign front  = bank_q[front_q];
  assign idx    = 9'(hpos >> 1);

  spi_read_engine #(.DATA_BITS(NB), .IW(IW)) u_eng (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (hmax),
    .addr_i      (target),
    .miso_i      (spi_miso),
    .cs_n_o      (spi_cs_n),
    .sclk_o      (spi_sclk),
    .mosi_o      (spi_mosi),
    .busy_o      (busy),
    .bit_valid_o (bit_valid),
    .bit_idx_o   (bit_idx),
    .bit_o       (bit_val)
  );

  // A bit landing on the swap edge belongs to the abandoned fetch, so it is dropped.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bank_q      <= '0;
      front_q     <= 1'b0;
      line_addr_q <= BASE_ADDR;
      underrun_q  <= 1'b0;
      pixel_q     <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      if (hmax) begin
        front_q     <= ~front_q;
        line_addr_q <= target + SPI_ADDR_W'(LINE_BYTES);
        underrun_q  <= underrun_q | busy;
      end else if (bit_valid) begin
        bank_q[~front_q][bit_idx] <= bit_val;
      end
      pixel_q <= visible && idx < 9'(NB) ? front[idx[IW-1:0]] : 1'b0;
      hsync_q <= hsync_in;
      vsync_q <= vsync_in;
    end

  assign pixel     = pixel_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;
  assign underrun  = underrun_q;
endmodule

// File: tb/tb_spi_line_fetch.sv
// tb_spi_line_fetch: scoreboard bench with an SPI ROM model checking fetch addresses and pixel/sync output.
module tb_spi_line_fetch;
  logic       clk = 0, reset_n = 0;
  logic [9:0] hpos = '0;
  logic       hmax = 0, vmax = 0, visible = 0, hsync_in = 0, vsync_in = 0, spi_miso = 0;
  logic       spi_cs_n, spi_sclk, spi_mosi, pixel, hsync_out, vsync_out, busy, underrun;

  int checks = 0, errors = 0;
  logic [23:0] addr_q[$];
  logic [2:0]  pix_q[$];

  spi_line_fetch dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .hmax(hmax), .vmax(vmax), .visible(visible),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .pixel(pixel), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    return a == 24'd0 ? 8'h80 : a == 24'd1 ? 8'h01 : 8'h00;
  endfunction

  // ROM model: collects the 32 header bits, then serves data one bit per sclk rise.
  int          rn = 0, j;
  logic [31:0] ca = '0;
  logic [7:0]  rb;
  logic [23:0] ea;
  always @(negedge spi_cs_n) rn = 0;
  always @(posedge clk) if (hmax && reset_n) rn = 0;
  always @(posedge spi_sclk) begin
    if (rn < 32) begin
      ca = {ca[30:0], spi_mosi};
      if (rn == 31) begin
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_addr_unexpected: got %h expected none", ca);
        end else begin
          ea = addr_q.pop_front();
          chk("cmd_addr", ca, {8'h03, ea});
        end
      end
    end else begin
      j = rn - 32;
      rb = rom_byte(ca[23:0] + 24'(j / 8));
      spi_miso = rb[7 - j % 8];
    end
    rn++;
  end

  logic [2:0] pe;
  initial forever begin
    @(posedge clk);
    #1;
    if (pix_q.size() != 0) begin
      pe = pix_q.pop_front();
      chk("pixel_sync", {29'd0, pixel, hsync_out, vsync_out}, {29'd0, pe});
    end
  end

  task automatic line_start(input logic vm, input logic [23:0] exp_addr);
    hmax = 1;
    vmax = vm;
    addr_q.push_back(exp_addr);
    @(negedge clk);
    hmax = 0;
    vmax = 0;
  endtask

  task automatic wait_idle();
    int n = 1;
    while (!spi_cs_n && n <= 1000) begin
      @(negedge clk);
      n++;
    end
    chk("cs_release_cycle", n, 417);
    chk("busy_release", busy, 0);
  endtask

  task automatic scan(input int lo, input int hi, input logic vis_en);
    logic [9:0] h;
    logic       v;
    for (int i = lo; i <= hi; i++) begin
      h = 10'(i);
      v = vis_en && !(i >= 100 && i < 120);
      hpos = h;
      visible = v;
      hsync_in = h[3];
      vsync_in = h[6];
      pix_q.push_back({v && (h[9:1] == 9'd0 || h[9:1] == 9'd15), h[3], h[6]});
      @(negedge clk);
    end
    visible = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    hpos = 10'd40; visible = 1; hmax = 1; hsync_in = 1; vsync_in = 1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_pixel", pixel, 0);
    chk("rst_hsync", hsync_out, 0);
    chk("rst_vsync", vsync_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    hmax = 0; visible = 0; hsync_in = 0; vsync_in = 0;
    reset_n = 1;
    @(negedge clk);
    chk("idle_cs_n", spi_cs_n, 1);
    line_start(1, 24'h000000);
    chk("start_cs_n", spi_cs_n, 0);
    chk("start_busy", busy, 1);
    wait_idle();
    line_start(0, 24'h000016);
    scan(0, 599, 1);
    scan(0, 31, 0);
    chk("fetch2_done", spi_cs_n, 1);
    line_start(0, 24'h00002C);
    wait_idle();
    chk("no_underrun", underrun, 0);
    line_start(1, 24'h000000);
    repeat (299) @(negedge clk);
    line_start(0, 24'h000016);
    chk("underrun_set", underrun, 1);
    chk("restart_cs_n", spi_cs_n, 0);
    chk("restart_sclk", spi_sclk, 0);
    repeat (299) @(negedge clk);
    line_start(0, 24'h00002C);
    chk("underrun_sticky", underrun, 1);
    wait_idle();
    chk("underrun_sticky2", underrun, 1);
    line_start(0, 24'h000042);
    repeat (150) @(negedge clk);
    chk("data_busy", busy, 1);
    reset_n = 0;
    #1;
    chk("async_cs_n", spi_cs_n, 1);
    chk("async_busy", busy, 0);
    chk("async_sclk", spi_sclk, 0);
    chk("async_underrun", underrun, 0);
    repeat (2) @(negedge clk);
    chk("addr_queue_drained", addr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
